// File: rtl/multicycle_processor.sv
// Multicycle processor: a four-step control FSM (T0..T3) drives a single muxed data bus.
// The bus feeds a register file, the A/G ALU staging registers and the zero flag.
module multicycle_processor #(
    parameter int DATA_WIDTH     = 9,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [DATA_WIDTH-1:0]     DIN,
    input  logic                      Run,
    output logic                      Done,
    output logic [DATA_WIDTH-1:0]     BusWires,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_sel,
    output logic [DATA_WIDTH-1:0]     dbg_data,
    output logic                      zero_flag
);

    localparam int NumRegs = 2 ** REG_ADDR_WIDTH;
    localparam int IrWidth = 3 + 2 * REG_ADDR_WIDTH;

    generate
        if (DATA_WIDTH < IrWidth) begin : gBadWidth
            $error("multicycle_processor: DATA_WIDTH must be at least 3 + 2*REG_ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OpMov  = 3'b000,
        OpMovi = 3'b001,
        OpAdd  = 3'b010,
        OpSub  = 3'b011,
        OpAnd  = 3'b100,
        OpMvnz = 3'b101,
        OpRes6 = 3'b110,
        OpRes7 = 3'b111
    } opcode_t;

    state_t                    state_q, state_d;
    logic [IrWidth-1:0]        ir_q;
    logic [DATA_WIDTH-1:0]     regs_q [NumRegs];
    logic [DATA_WIDTH-1:0]     a_q;
    logic [DATA_WIDTH-1:0]     g_q;
    logic                      z_q;

    opcode_t                   opcode;
    logic [REG_ADDR_WIDTH-1:0] xIdx;
    logic [REG_ADDR_WIDTH-1:0] yIdx;
    logic                      irLoad;
    logic                      regWrite;
    logic                      aLoad;
    logic                      gLoad;
    logic [DATA_WIDTH-1:0]     aluResult;

    // Only the opcode and register fields are kept; the unused low bits of DIN are dropped.
    assign opcode = opcode_t'(ir_q[IrWidth-1 -: 3]);
    assign xIdx   = ir_q[IrWidth-4 -: REG_ADDR_WIDTH];
    assign yIdx   = ir_q[IrWidth-4-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];

    assign dbg_data  = regs_q[dbg_sel];
    assign zero_flag = z_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        BusWires = '0;
        Done     = 1'b0;
        irLoad   = 1'b0;
        regWrite = 1'b0;
        aLoad    = 1'b0;
        gLoad    = 1'b0;
        case (state_q)
            T0: begin
                if (Run) begin
                    irLoad  = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                Done    = 1'b1;
                state_d = T0;
                case (opcode)
                    OpMov: begin
                        BusWires = regs_q[yIdx];
                        regWrite = 1'b1;
                    end
                    OpMovi: begin
                        BusWires = DIN;
                        regWrite = 1'b1;
                    end
                    OpAdd, OpSub, OpAnd: begin
                        BusWires = regs_q[xIdx];
                        aLoad    = 1'b1;
                        Done     = 1'b0;
                        state_d  = T2;
                    end
                    OpMvnz: begin
                        if (!z_q) begin
                            BusWires = regs_q[yIdx];
                            regWrite = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            T2: begin
                BusWires = regs_q[yIdx];
                gLoad    = 1'b1;
                state_d  = T3;
            end
            T3: begin
                BusWires = g_q;
                regWrite = 1'b1;
                Done     = 1'b1;
                state_d  = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

    // Carry and borrow fall off the top: results wrap modulo 2**DATA_WIDTH.
    always_comb begin
        aluResult = '0;
        case (opcode)
            OpAdd:   aluResult = a_q + BusWires;
            OpSub:   aluResult = a_q - BusWires;
            OpAnd:   aluResult = a_q & BusWires;
            default: aluResult = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ir_q <= '0;
            a_q  <= '0;
            g_q  <= '0;
            z_q  <= 1'b1;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (irLoad) begin
                ir_q <= DIN[DATA_WIDTH-1 -: IrWidth];
            end
            if (regWrite) begin
                regs_q[xIdx] <= BusWires;
            end
            if (aLoad) begin
                a_q <= BusWires;
            end
            if (gLoad) begin
                g_q <= aluResult;
                z_q <= (aluResult == '0);
            end
        end
    end

endmodule
